// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing scheduler.
// Imported by mult_share_rr_pick and mult_share_ctrl.
package mult_share_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Requester index reached by stepping 'offset' places past 'base', wrapping at n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/mult_share_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_grant,
// wrapping from NUM_REQ-1 back to 0.
module mult_share_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    sel,
    output logic               any_valid
);
    import mult_share_pkg::*;

    // Scan offsets from farthest to nearest so the nearest valid requester wins.
    always_comb begin
        sel       = last_grant;
        any_valid = |req_valid;
        for (int i = NUM_REQ; i >= 1; i--) begin
            sel = req_valid[rr_index(int'(last_grant), i, NUM_REQ)]
                ? ID_W'(rr_index(int'(last_grant), i, NUM_REQ)) : sel;
        end
    end

endmodule

// File: rtl/multiplier_16bits_version4.sv
// Combinational 16x16 unsigned multiplier with a full-width 32-bit product.
module multiplier_16bits_version4 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [31:0] product
);

    assign product = 32'(a) * 32'(b);

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin scheduler sharing one 16x16 multiplier among NUM_REQ requesters.
// Optional build macro MULT_SHARE_PERF_EN adds the perf_ops completion counter.
module mult_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_product,
    output logic                  busy
`ifdef MULT_SHARE_PERF_EN
    ,
    output logic [31:0]           perf_ops
`endif
);
    import mult_share_pkg::*;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;

    logic [ID_W-1:0]     sel_s;
    logic                any_valid_s;
    logic [PROD_W-1:0]   mult_out_s;
    logic [NUM_REQ-1:0]  grant_s;
    logic                rsp_done_s;

    mult_share_rr_pick #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .last_grant(last_grant_q),
        .sel       (sel_s),
        .any_valid (any_valid_s)
    );

    multiplier_16bits_version4 u_mult (
        .a      (a_q),
        .b      (b_q),
        .product(mult_out_s)
    );

    // Grant is only offered from IDLE, and is held low while reset is asserted.
    always_comb begin
        grant_s = '0;
        if (rst_n && (state_q == IDLE) && any_valid_s) begin
            grant_s[sel_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    assign req_ready  = grant_s;
    assign rsp_done_s = (state_q == RESP) && rsp_ready;

    // Next-state and datapath capture for the IDLE -> CALC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        prod_d       = prod_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    a_d          = req_a[sel_s*OP_W +: OP_W];
                    b_d          = req_b[sel_s*OP_W +: OP_W];
                    id_d         = sel_s;
                    last_grant_d = sel_s;
                    state_d      = CALC;
                end else begin
                    state_d      = IDLE;
                end
            end
            CALC: begin
                prod_d  = mult_out_s;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // Controller state, operand/result registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            prod_q       <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            prod_q       <= prod_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = id_q;
    assign rsp_product = prod_q;
    assign busy        = busy_q;

`ifdef MULT_SHARE_PERF_EN
    logic [PERF_W-1:0] perf_ops_q, perf_ops_d;

    // Count completed response handshakes; wraps naturally at 2^32.
    always_comb begin
        perf_ops_d = perf_ops_q;
        if (rsp_done_s) begin
            perf_ops_d = perf_ops_q + 32'd1;
        end else begin
            perf_ops_d = perf_ops_q;
        end
    end

    // Completion counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q <= '0;
        end else begin
            perf_ops_q <= perf_ops_d;
        end
    end

    assign perf_ops = perf_ops_q;
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: vector table, hand sequences for
// throughput/backpressure/reset, and randomized operations against a reference model.
module tb_mult_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*16-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_product;
    logic                  busy;
`ifdef MULT_SHARE_PERF_EN
    logic [31:0]           perf_ops;
`endif

    mult_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_product(rsp_product),
        .busy       (busy)
`ifdef MULT_SHARE_PERF_EN
        ,
        .perf_ops   (perf_ops)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] la [NUM_REQ];
    logic [15:0] lb [NUM_REQ];
    int lg_m;
    int ops_m;

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] a;
        logic [15:0] b;
        int          exp_id;
        logic [31:0] exp_prod;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] mask);
        req_valid = mask;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*16 +: 16] = la[i];
            req_b[i*16 +: 16] = lb[i];
        end
    endtask

    // Reference arbitration: first set bit of mask after position lg, wrapping.
    function automatic int pick(input logic [3:0] mask, input int lg);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (mask[(lg + i) % NUM_REQ]) return (lg + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] r;
        r = 4'b0001;
        return r << i;
    endfunction

    function automatic logic [31:0] mul(input logic [15:0] a, input logic [15:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(4'b1111);
        #1;
        check("rst_ready", 64'(req_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_product", 64'(rsp_product), 64'h0);
        check("rst_id", 64'(rsp_id), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        drive(4'b0000);
        rst_n = 1'b1;
        lg_m  = NUM_REQ - 1;
        ops_m = 0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grant_id  [$];
        int   grant_cyc [$];
        int   gid, exp_id, stall;
        logic [31:0] held_prod;
        logic [3:0]  mask;

        vecs[0] = '{4'b0100, 16'h1234, 16'h0010, 2, 32'h0001_2340};
        vecs[1] = '{4'b1111, 16'hFFFF, 16'hFFFF, 3, 32'hFFFE_0001};
        vecs[2] = '{4'b1111, 16'h0000, 16'hABCD, 0, 32'h0000_0000};
        vecs[3] = '{4'b1001, 16'h8000, 16'h0002, 3, 32'h0001_0000};
        vecs[4] = '{4'b0011, 16'h00FF, 16'h0101, 0, 32'h0000_FFFF};
        vecs[5] = '{4'b0010, 16'h0003, 16'h0005, 1, 32'h0000_000F};

        for (int i = 0; i < NUM_REQ; i++) begin
            la[i] = 16'h0;
            lb[i] = 16'h0;
        end
        do_reset();

        // Table of single operations with rsp_ready held high.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                la[i] = vecs[v].a;
                lb[i] = vecs[v].b;
            end
            drive(vecs[v].mask);
            #1;
            check("vec_ready", 64'(req_ready), 64'(onehot(vecs[v].exp_id)));
            check("vec_idle_busy", 64'(busy), 64'h0);
            tick();
            drive(4'b0000);
            check("vec_calc_busy", 64'(busy), 64'h1);
            check("vec_calc_rsp_valid", 64'(rsp_valid), 64'h0);
            check("vec_calc_ready", 64'(req_ready), 64'h0);
            tick();
            check("vec_rsp_valid", 64'(rsp_valid), 64'h1);
            check("vec_rsp_id", 64'(rsp_id), 64'(vecs[v].exp_id));
            check("vec_rsp_product", 64'(rsp_product), 64'(vecs[v].exp_prod));
            tick();
            check("vec_done_valid", 64'(rsp_valid), 64'h0);
            check("vec_done_busy", 64'(busy), 64'h0);
            lg_m = vecs[v].exp_id;
            ops_m++;
        end

        // Backpressure: response held for several cycles with other requesters waiting.
        la[1] = 16'h00AB;
        lb[1] = 16'h0C0D;
        rsp_ready = 1'b0;
        drive(4'b0010);
        #1;
        exp_id = pick(4'b0010, lg_m);
        check("bp_ready", 64'(req_ready), 64'(onehot(exp_id)));
        tick();
        drive(4'b1111);
        check("bp_calc_ready", 64'(req_ready), 64'h0);
        tick();
        lg_m = exp_id;
        for (int s = 0; s < 5; s++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'h1);
            check("bp_rsp_product", 64'(rsp_product), 64'(mul(16'h00AB, 16'h0C0D)));
            check("bp_rsp_id", 64'(rsp_id), 64'(exp_id));
            check("bp_ready_low", 64'(req_ready), 64'h0);
            check("bp_busy", 64'(busy), 64'h1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        ops_m++;
        check("bp_release_busy", 64'(busy), 64'h0);
        check("bp_release_valid", 64'(rsp_valid), 64'h0);
        check("bp_next_ready", 64'(req_ready), 64'(onehot(pick(4'b1111, lg_m))));
        drive(4'b0000);

        // Throughput from reset: all requesters continuously valid.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            la[i] = 16'h1000 + 16'(i) * 16'h0111;
            lb[i] = 16'h0020 + 16'(i);
        end
        drive(4'b1111);
        for (int cyc = 0; cyc < 16; cyc++) begin
            #1;
            if (req_ready != 4'b0000) begin
                gid = -1;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gid = i;
                check("tp_onehot", 64'($countones(req_ready)), 64'h1);
                check("tp_grant_id", 64'(gid), 64'(pick(4'b1111, lg_m)));
                lg_m = gid;
                grant_id.push_back(gid);
                grant_cyc.push_back(cyc);
            end
            if (rsp_valid) begin
                check("tp_product", 64'(rsp_product), 64'(mul(la[rsp_id], lb[rsp_id])));
                ops_m++;
            end
            tick();
        end
        drive(4'b0000);
        check("tp_first_grant", 64'(grant_id[0]), 64'h0);
        check("tp_num_grants", 64'(grant_id.size()), 64'd6);
        for (int k = 1; k < grant_cyc.size(); k++) begin
            check("tp_spacing", 64'(grant_cyc[k] - grant_cyc[k-1]), 64'd3);
        end
        for (int k = 0; k < 10; k++) begin
            #1;
            if (rsp_valid) begin
                check("tp_drain_product", 64'(rsp_product), 64'(mul(la[rsp_id], lb[rsp_id])));
                ops_m++;
            end
            if (!busy) break;
            tick();
        end
        check("tp_drain_idle", 64'(busy), 64'h0);

        // Reset while in CALC: outputs clear at once and priority returns to requester 0.
        la[2] = 16'h4321;
        lb[2] = 16'h0077;
        la[0] = 16'h0102;
        lb[0] = 16'h0304;
        la[3] = 16'hBEEF;
        lb[3] = 16'h0002;
        drive(4'b0100);
        #1;
        check("rc_ready", 64'(req_ready), 64'(onehot(pick(4'b0100, lg_m))));
        tick();
        drive(4'b1001);
        check("rc_busy_before", 64'(busy), 64'h1);
        rst_n = 1'b0;
        #1;
        check("rc_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rc_busy", 64'(busy), 64'h0);
        check("rc_ready_in_rst", 64'(req_ready), 64'h0);
        check("rc_product", 64'(rsp_product), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        lg_m  = NUM_REQ - 1;
        ops_m = 0;
        #1;
        check("rc_prio0", 64'(req_ready), 64'(onehot(0)));
        tick();
        drive(4'b0000);
        tick();
        check("rc_rsp_valid_after", 64'(rsp_valid), 64'h1);
        check("rc_rsp_id_after", 64'(rsp_id), 64'h0);
        check("rc_product_after", 64'(rsp_product), 64'(mul(16'h0102, 16'h0304)));
        lg_m = 0;
        tick();
        ops_m++;

        // Randomized operations with random masks, operands and response stalls.
        for (int it = 0; it < 40; it++) begin
            mask = 4'($urandom_range(0, 15));
            for (int i = 0; i < NUM_REQ; i++) begin
                la[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                lb[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            end
            drive(mask);
            #1;
            if (mask == 4'b0000) begin
                check("rnd_idle_ready", 64'(req_ready), 64'h0);
                tick();
                check("rnd_idle_busy", 64'(busy), 64'h0);
                continue;
            end
            exp_id = pick(mask, lg_m);
            check("rnd_ready", 64'(req_ready), 64'(onehot(exp_id)));
            tick();
            drive(4'b0000);
            stall     = $urandom_range(0, 3);
            rsp_ready = (stall == 0);
            held_prod = mul(la[exp_id], lb[exp_id]);
            tick();
            check("rnd_rsp_valid", 64'(rsp_valid), 64'h1);
            check("rnd_rsp_id", 64'(rsp_id), 64'(exp_id));
            check("rnd_rsp_product", 64'(rsp_product), 64'(held_prod));
            for (int s = 0; s < stall; s++) begin
                tick();
                check("rnd_hold_valid", 64'(rsp_valid), 64'h1);
                check("rnd_hold_product", 64'(rsp_product), 64'(held_prod));
            end
            rsp_ready = 1'b1;
            tick();
            check("rnd_done_busy", 64'(busy), 64'h0);
            lg_m = exp_id;
            ops_m++;
        end

`ifdef MULT_SHARE_PERF_EN
        check("perf_ops", 64'(perf_ops), 64'(ops_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Round-robin scheduler that shares one combinational 16x16 unsigned multiplier (`multiplier_16bits_version4`) among NUM_REQ requesters. It accepts one operand pair at a time over a valid/ready handshake and registers the operands. It then registers the 32-bit product after a dedicated settle cycle and returns it with the requester ID over a valid/ready response channel. It sits between the datapath clients and the shared multiplier instance.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- ID_W, $clog2(NUM_REQ), requester ID width
- clk  in  1  rising-edge clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester operand request
- req_ready  out  NUM_REQ  one-hot grant/accept, at most one bit high
- req_a  in  NUM_REQ*16  operand A, requester i at bits [16i+15:16i]
- req_b  in  NUM_REQ*16  operand B, same packing
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  ID_W  requester index of the result
- rsp_product  out  32  A*B, unsigned
- busy  out  1  high in any state other than IDLE
- perf_ops  out  32  completed-operation count; exists only with MULT_SHARE_PERF_EN

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - The picker selects the first requester with req_valid=1, searching upward from last_grant+1 with wrap at NUM_REQ-1 to 0.
  - req_ready[sel] is driven combinationally from req_valid and the state.
  - The handshake completes in the same cycle. On that edge the block latches a_r, b_r and id_r, sets last_grant=sel, and moves to CALC.
  - If no request is valid, the block stays in IDLE and req_ready is 0.
- **CALC**
  - a_r and b_r drive the multiplier.
  - On the clock edge, prod_r <= the multiplier output, and the state moves to RESP.
  - req_ready is 0.
- **RESP**
  - rsp_valid=1, rsp_product=prod_r, rsp_id=id_r.
  - These outputs stay stable until rsp_valid&rsp_ready. On that edge the block returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Requesters hold valid and data until their ready bit is asserted. If a requester drops valid before it is granted, no operation is recorded for it.
- last_grant changes only on an accepted request. A requester that is not granted keeps its position in the rotation.
- Arithmetic: unsigned, full 32-bit product with no truncation. 0xFFFF*0xFFFF = 0xFFFE0001.
- Reset (asserted at any time, including mid-operation):
  - state=IDLE, last_grant=NUM_REQ-1 so requester 0 has first priority.
  - a_r, b_r, prod_r, id_r = 0.
  - rsp_valid=0, req_ready=0, busy=0, perf_ops=0.
  - An in-flight operation is discarded silently.

## Timing
- Request accepted at edge E0 → rsp_valid high in the cycle after E1, i.e. 2 cycles after the request handshake.
- Peak throughput: one operation every 3 cycles, assuming rsp_ready is held high.
- Only req_ready is combinational (from req_valid, state and last_grant). All other outputs are registered.
- The multiplier path (a_r/b_r → prod_r) gets a full clock period. No multicycle constraints are needed.
- Reset release: the first accept is possible on the first rising edge after rst_n deasserts.

## Configuration
- MULT_SHARE_PERF_EN defined:
  - Adds a 32-bit perf_ops output.
  - perf_ops increments on each rsp_valid&rsp_ready and wraps from 0xFFFFFFFF to 0.
  - perf_ops is reset to 0 by rst_n.
- Undefined: the perf_ops port and the counter do not exist. All other behaviour is identical.

## Structure
- Package mult_share_pkg holds:
  - OP_W=16, PROD_W=32
  - the state enum (IDLE, CALC, RESP)
  - the PERF_W=32 constant
- Sub-module mult_share_rr_pick: purely combinational round-robin picker.
  - Inputs: req_valid, last_grant.
  - Outputs: sel index, any_valid.
- The top instantiates mult_share_rr_pick and one `multiplier_16bits_version4`.

## Test plan
- Single request: req_valid[2]=1, A=0x1234, B=0x0010 → req_ready[2] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_product=0x00012340.
- All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0, each 3 cycles apart; products are correct per ID.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_product and rsp_id are held stable, req_ready stays 0, busy=1; after rsp_ready rises, IDLE is reached on the next edge.
- Corners: 0xFFFF*0xFFFF → 0xFFFE0001; 0x0000*0xABCD → 0; 0x8000*0x0002 → 0x00010000.
- Reset asserted in CALC → outputs immediately 0 and state IDLE; after release, requester 0 wins over 3 when both are valid.
- MULT_SHARE_PERF_EN: 7 completed operations → perf_ops=7; with the macro undefined, the bench compiles without the port.
